// File: rtl/vga_frame_sink_pkg.sv
// Shared timing types, the 640x480 mode constant and the sink FSM encoding.
package vga_frame_sink_pkg;

  typedef struct packed {
    logic [10:0] active;
    logic [10:0] fp;
    logic [10:0] sync;
    logic [10:0] bp;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480 = '{
    h: '{active: 11'd640, fp: 11'd16, sync: 11'd96, bp: 11'd48},
    v: '{active: 11'd480, fp: 11'd10, sync: 11'd2,  bp: 11'd33}
  };

  typedef enum logic [1:0] {SEARCH, WAIT_V, LOCKED} sink_state_e;

  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

endpackage

// File: rtl/vga_frame_sink_axis.sv
// One timing axis: sync edge detect, saturating position counter, pulse width and period checks.
module vga_axis_counter #(
  parameter int CW       = 11,
  parameter int SYNC_LEN = 96,
  parameter int TOTAL    = 800
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_adv,
  input  logic          i_sync,
  output logic [CW-1:0] cnt_cur,
  output logic          rise,
  output logic          err_width,
  output logic          err_period
);

  localparam logic [CW:0] SYNC_L  = (CW+1)'(SYNC_LEN);
  localparam logic [CW:0] TOTAL_L = (CW+1)'(TOTAL);

  logic          sync_prev, seen, fall;
  logic [CW-1:0] cnt, cnt_inc;
  logic [CW:0]   cnt_p1;

  assign cnt_p1  = {1'b0, cnt} + (CW+1)'(1);
  assign cnt_inc = (&cnt) ? cnt : cnt_p1[CW-1:0];
  assign rise    = i_adv & i_sync & ~sync_prev;
  assign fall    = i_adv & ~i_sync & sync_prev;

  // Position of the sample being taken this cycle; the stored count otherwise.
  assign cnt_cur = !i_adv ? cnt : (rise ? '0 : cnt_inc);

  assign err_width  = fall & seen & (cnt_p1 != SYNC_L);
  assign err_period = rise & seen & (cnt_p1 != TOTAL_L);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync_prev <= 1'b0;
      seen      <= 1'b0;
      cnt       <= '0;
    end else if (i_adv) begin
      sync_prev <= i_sync;
      cnt       <= cnt_cur;
      if (rise) seen <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_frame_sink.sv
// VGA receive monitor: recovers timing from sync inputs, emits active pixels, frame checksum and error flags.
module vga_frame_sink
  import vga_frame_sink_pkg::*;
#(
  parameter int   H_ACTIVE    = int'(VGA_640x480.h.active),
  parameter int   H_FP        = int'(VGA_640x480.h.fp),
  parameter int   H_SYNC      = int'(VGA_640x480.h.sync),
  parameter int   H_BP        = int'(VGA_640x480.h.bp),
  parameter int   V_ACTIVE    = int'(VGA_640x480.v.active),
  parameter int   V_FP        = int'(VGA_640x480.v.fp),
  parameter int   V_SYNC      = int'(VGA_640x480.v.sync),
  parameter int   V_BP        = int'(VGA_640x480.v.bp),
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_ce,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [11:0] i_rgb,
  input  logic        i_clr_err,
  output logic        o_locked,
  output logic        o_pix_valid,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic [11:0] o_rgb,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic [31:0] o_frame_chk,
  output logic        o_err_hwidth,
  output logic        o_err_hperiod,
  output logic        o_err_vwidth,
  output logic        o_err_vperiod
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LO   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_HI   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

  sink_state_e st, st_nxt;
  logic        hs, vs, h_rise, h_errw, h_errp, v_rise, v_errw, v_errp, any_err;
  logic [10:0] hcur;
  logic [9:0]  vcur;
  logic        armed, pix_act, valid, fs, fd;
  logic [31:0] chk, chk_nxt;

  assign hs = (i_hsync == SYNC_ACTIVE);
  assign vs = (i_vsync == SYNC_ACTIVE);

  vga_axis_counter #(.CW(11), .SYNC_LEN(H_SYNC), .TOTAL(H_TOTAL)) u_h (
    .i_clk, .i_rst, .i_adv(i_pix_ce), .i_sync(hs),
    .cnt_cur(hcur), .rise(h_rise), .err_width(h_errw), .err_period(h_errp)
  );

  // Vertical axis advances once per line and only looks at vsync on the hsync rise.
  vga_axis_counter #(.CW(10), .SYNC_LEN(V_SYNC), .TOTAL(V_TOTAL)) u_v (
    .i_clk, .i_rst, .i_adv(h_rise), .i_sync(vs),
    .cnt_cur(vcur), .rise(v_rise), .err_width(v_errw), .err_period(v_errp)
  );

  assign any_err = h_errw | h_errp | v_errw | v_errp;

  always_comb begin
    st_nxt = st;
    case (st)
      SEARCH:  if (h_rise) st_nxt = WAIT_V;
      WAIT_V:  if (v_rise) st_nxt = LOCKED;
      LOCKED:  st_nxt = LOCKED;
      default: st_nxt = SEARCH;
    endcase
    if (any_err) st_nxt = SEARCH;
  end

  assign pix_act = i_pix_ce & (hcur >= H_LO) & (hcur < H_HI) & (vcur >= V_LO) & (vcur < V_HI);
  assign valid   = pix_act & (st_nxt == LOCKED);
  // Frame strobes only for frames whose line 0 was entered while already locked.
  assign fs      = valid & armed & (hcur == H_LO) & (vcur == V_LO);
  assign fd      = valid & armed & (hcur == H_LAST) & (vcur == V_LAST);
  assign chk_nxt = rotl1(fs ? 32'h0 : chk) ^ {20'b0, i_rgb};
  assign o_locked = (st == LOCKED);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      st            <= SEARCH;
      armed         <= 1'b0;
      chk           <= '0;
      o_pix_valid   <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_rgb         <= '0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_chk   <= '0;
      o_err_hwidth  <= 1'b0;
      o_err_hperiod <= 1'b0;
      o_err_vwidth  <= 1'b0;
      o_err_vperiod <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st_nxt != LOCKED)             armed <= 1'b0;
      else if (v_rise && st == LOCKED) armed <= 1'b1;
      o_pix_valid   <= valid;
      o_frame_start <= fs;
      o_frame_done  <= fd;
      if (valid) begin
        o_x   <= 10'(hcur - H_LO);
        o_y   <= vcur - V_LO;
        o_rgb <= i_rgb;
        chk   <= chk_nxt;
      end
      if (fd) o_frame_chk <= chk_nxt;
      o_err_hwidth  <= h_errw | (o_err_hwidth  & ~i_clr_err);
      o_err_hperiod <= h_errp | (o_err_hperiod & ~i_clr_err);
      o_err_vwidth  <= v_errw | (o_err_vwidth  & ~i_clr_err);
      o_err_vperiod <= v_errp | (o_err_vperiod & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_vga_frame_sink.sv
// Scoreboard bench: reduced-size timing, one active-low and one active-high sink fed the same frames.
module tb_vga_frame_sink;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, clr = 1'b0, ce_q = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1;
  logic [11:0] rgb = '0;

  logic [1:0] locked, pv, fs, fd, eh, ep, evw, evp;
  logic [1:0][9:0]  ox, oy;
  logic [1:0][11:0] orgb;
  logic [1:0][31:0] ochk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        fs;
    logic        fd;
    logic [31:0] chk;
  } exp_t;

  exp_t q0[$], q1[$];
  int checks = 0, failures = 0;
  int pf_cnt[2];

  // Bench model state: 0 search, 1 wait for vsync, 2 locked.
  int m_st = 0, fno = 0;
  bit m_armed = 0;
  logic [31:0] m_chk = '0, last_chk = '0;
  int k_hw_line = -1, k_long_line = -1, k_gap_line = -1, k_rst_line = -1;
  bit k_extra = 0, vper_pend = 0, hper_pend = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ce_q <= ce;

  vga_frame_sink #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_pix_ce(ce), .i_hsync(hsync), .i_vsync(vsync),
    .i_rgb(rgb), .i_clr_err(clr), .o_locked(locked[0]), .o_pix_valid(pv[0]),
    .o_x(ox[0]), .o_y(oy[0]), .o_rgb(orgb[0]), .o_frame_start(fs[0]), .o_frame_done(fd[0]),
    .o_frame_chk(ochk[0]), .o_err_hwidth(eh[0]), .o_err_hperiod(ep[0]),
    .o_err_vwidth(evw[0]), .o_err_vperiod(evp[0]));

  vga_frame_sink #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_pix_ce(ce), .i_hsync(~hsync), .i_vsync(~vsync),
    .i_rgb(rgb), .i_clr_err(clr), .o_locked(locked[1]), .o_pix_valid(pv[1]),
    .o_x(ox[1]), .o_y(oy[1]), .o_rgb(orgb[1]), .o_frame_start(fs[1]), .o_frame_done(fd[1]),
    .o_frame_chk(ochk[1]), .o_err_hwidth(eh[1]), .o_err_hperiod(ep[1]),
    .o_err_vwidth(evw[1]), .o_err_vperiod(evp[1]));

  task automatic check(input string n, input int d, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", n, d, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string n);
    for (int d = 0; d < 2; d++) begin
      check({n, "_pos"}, d, 64'({ox[d], oy[d], orgb[d]}), 64'h0);
      check({n, "_chk"}, d, 64'(ochk[d]), 64'h0);
      check({n, "_flags"}, d, 64'({locked[d], pv[d], fs[d], fd[d], eh[d], ep[d], evw[d], evp[d]}), 64'h0);
    end
  endtask

  task automatic check_state(input string n, input logic lk, input logic [3:0] errs);
    for (int d = 0; d < 2; d++) begin
      check({n, "_locked"}, d, 64'(locked[d]), 64'(lk));
      check({n, "_errs"}, d, 64'({eh[d], ep[d], evw[d], evp[d]}), 64'(errs));
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    check("orphan_strobe", d, 64'((fs[d] | fd[d]) & ~pv[d]), 64'h0);
    check("valid_latency", d, 64'(pv[d] & ~ce_q), 64'h0);
    if (!pv[d]) return;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      check("unexpected_pixel", d, 64'({ox[d], oy[d]}), 64'hFFFFF);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check("pixel", d, 64'({ox[d], oy[d], orgb[d], fs[d], fd[d]}), 64'({e.x, e.y, e.rgb, e.fs, e.fd}));
    pf_cnt[d] = fs[d] ? 1 : pf_cnt[d] + 1;
    if (fd[d]) begin
      check("frame_chk", d, 64'(ochk[d]), 64'(e.chk));
      check("frame_pixels", d, 64'(pf_cnt[d]), 64'(HA * VA));
    end
  endtask

  always @(negedge clk) for (int d = 0; d < 2; d++) mon(d);

  task automatic push(input int x, input int y, input logic [11:0] c);
    exp_t e;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.rgb = c;
    e.fs  = m_armed && x == 0 && y == 0;
    e.fd  = m_armed && x == HA - 1 && y == VA - 1;
    m_chk = e.fs ? {20'b0, c} : ({m_chk[30:0], m_chk[31]} ^ {20'b0, c});
    e.chk = m_chk;
    if (e.fd) last_chk = m_chk;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic px(input logic h, input logic v, input logic [11:0] c, input logic r, input logic cl);
    hsync = ~h; vsync = ~v; rgb = c; rst_n = ~r; clr = cl; ce = 1'b1;
    @(posedge clk); #1;
    if (r) check_zero("mid_reset");
    rst_n = 1'b1; clr = 1'b0; ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic line(input int ln);
    int len, hsw, x, y;
    bit err0, act, r;
    logic [11:0] c;
    hsw  = (ln == k_hw_line) ? HS - 1 : HS;
    len  = (ln == k_long_line) ? HT + 1 : HT;
    err0 = (ln == 0 && vper_pend) || hper_pend;
    if (ln == 0) vper_pend = 0;
    hper_pend = (ln == k_long_line);
    for (int p = 0; p < len; p++) begin
      r = (ln == k_rst_line) && (p == HS + HB + HA / 2);
      if (p == 0) begin
        if (err0) begin m_st = 0; m_armed = 0; end
        else if (m_st == 0) m_st = 1;
        else if (ln == 0) begin
          if (m_st == 1) m_st = 2; else m_armed = 1;
        end
      end
      if ((ln == k_hw_line && p == hsw) || r) begin m_st = 0; m_armed = 0; end
      x = p - (HS + HB);
      y = ln - (VS + VB);
      act = x >= 0 && x < HA && y >= 0 && y < VA && !r;
      c = act ? 12'((x ^ (y << 5)) ^ (fno << 8)) : 12'hA5A;
      if (act && m_st == 2) push(x, y, c);
      px(p < hsw, ln < VS, c, r, ln == k_hw_line && p == hsw);
      if (ln == k_hw_line && p == hsw) check_state("hwidth_hit", 1'b0, 4'b1000);
      if (ln == k_gap_line && p == HS + HB + 1) begin
        repeat (1000) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic frame();
    int n;
    n = VT + (k_extra ? 1 : 0);
    for (int ln = 0; ln < n; ln++) line(ln);
    if (k_extra) vper_pend = 1;
    fno++;
  endtask

  task automatic knobs_clear();
    k_hw_line = -1; k_long_line = -1; k_gap_line = -1; k_rst_line = -1; k_extra = 0;
  endtask

  task automatic clear_errs();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_state("after_clear", 1'b1, 4'b0000);
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Nominal: lock on the second vsync, full frames reported from the third.
    frame(); frame();
    check_state("lock_2frames", 1'b1, 4'b0000);
    frame(); frame();
    for (int d = 0; d < 2; d++) check("chk_held", d, 64'(ochk[d]), 64'(last_chk));

    // Short hsync pulse: drop lock, relock, flag sticky until cleared.
    k_hw_line = 1; frame(); knobs_clear();
    frame(); frame();
    check_state("hwidth_sticky", 1'b1, 4'b1000);
    clear_errs();

    // Long line, then long frame.
    k_long_line = 3; frame(); knobs_clear();
    frame(); frame();
    check_state("hperiod", 1'b1, 4'b0100);
    clear_errs();
    k_extra = 1; frame(); knobs_clear();
    frame(); frame(); frame();
    check_state("vperiod", 1'b1, 4'b0001);
    clear_errs();

    // Pixel strobe gated off mid-line.
    k_gap_line = 4; frame(); knobs_clear();
    check_state("ce_gap", 1'b1, 4'b0000);

    // Reset mid-frame: the next completed frame starts at the second vsync after release.
    k_rst_line = 5; frame(); knobs_clear();
    frame();
    for (int d = 0; d < 2; d++) check("chk_after_reset", d, 64'(ochk[d]), 64'h0);
    frame();
    for (int d = 0; d < 2; d++) check("chk_relock", d, 64'(ochk[d]), 64'(last_chk));
    check_state("final", 1'b1, 4'b0000);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 0, 64'(q0.size()), 64'h0);
    check("queue_empty", 1, 64'(q1.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
